// File: rtl/mips_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mips_pkg : shared constants, state codes and helpers for the
//            multicycle MIPS core
// Rev 1.0
// ------------------------------------------------------------------
package mips_pkg;

  localparam logic [3:0] c_FETCH  = 4'd0;
  localparam logic [3:0] c_DECODE = 4'd1;
  localparam logic [3:0] c_MEMADR = 4'd2;
  localparam logic [3:0] c_MEMRD  = 4'd3;
  localparam logic [3:0] c_MEMWB  = 4'd4;
  localparam logic [3:0] c_MEMWR  = 4'd5;
  localparam logic [3:0] c_EXEC   = 4'd6;
  localparam logic [3:0] c_ALUWB  = 4'd7;
  localparam logic [3:0] c_BRANCH = 4'd8;
  localparam logic [3:0] c_ADDIEX = 4'd9;
  localparam logic [3:0] c_ADDIWB = 4'd10;
  localparam logic [3:0] c_JUMP   = 4'd11;
  localparam logic [3:0] c_HALT   = 4'd12;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  function automatic logic [31:0] signExt(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Unsupported funct codes fall back to add.
  function automatic logic [2:0] functToAlu(input logic [5:0] funct);
    case (funct)
      c_FN_SUB: return c_ALU_SUB;
      c_FN_AND: return c_ALU_AND;
      c_FN_OR:  return c_ALU_OR;
      c_FN_SLT: return c_ALU_SLT;
      default:  return c_ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ------------------------------------------------------------------
// alu : 32-bit add/sub/and/or/slt with zero flag
// Rev 1.0
// ------------------------------------------------------------------
module alu
  import mips_pkg::*;
(
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [2:0]  iCtrl,
  output logic [31:0] oY,
  output logic        oZero
);

  always_comb begin
    case (iCtrl)
      c_ALU_AND: oY = iA & iB;
      c_ALU_OR:  oY = iA | iB;
      c_ALU_SUB: oY = iA - iB;
      c_ALU_SLT: oY = {31'd0, $signed(iA) < $signed(iB)};
      default:   oY = iA + iB;
    endcase
  end

  assign oZero = (oY == 32'd0);

endmodule
`default_nettype wire

// File: rtl/dmem.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem : 64-word data RAM, combinational read, clocked write
// Rev 1.0
// ------------------------------------------------------------------
module dmem (
  input  logic        iClk,
  input  logic        iWe,
  input  logic [5:0]  iAddr,
  input  logic [31:0] iWd,
  output logic [31:0] oRd
);

  logic [31:0] r_mem [64];

  always_ff @(posedge iClk) begin
    if (iWe) r_mem[iAddr] <= iWd;
  end

  assign oRd = r_mem[iAddr];

endmodule
`default_nettype wire

// File: rtl/imem.sv
`default_nettype none
// ------------------------------------------------------------------
// imem : 64-word instruction ROM, contents fixed by parameter
// Rev 1.0
// ------------------------------------------------------------------
module imem #(
  parameter logic [63:0][31:0] INIT = '0
) (
  input  logic [5:0]  iAddr,
  output logic [31:0] oRd
);

  assign oRd = INIT[iAddr];

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_controller : multicycle MIPS FSM and decoded control strobes
// Rev 1.0
// ------------------------------------------------------------------
module mc_controller
  import mips_pkg::*;
#(
  parameter logic TRAP_ILLEGAL = 1'b0
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [5:0] iOp,
  input  logic [5:0] iFunct,
  output logic [3:0] oState,
  output logic       oIRWrite,
  output logic       oPCWrite,
  output logic       oPCWriteCond,
  output logic       oRegWrite,
  output logic       oRegDst,
  output logic       oMemtoReg,
  output logic       oMemWrite,
  output logic       oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oPCSrc,
  output logic [2:0] oALUControl,
  output logic       oAbWrite,
  output logic       oMdrWrite,
  output logic       oAluOutWrite,
  output logic       oRetire,
  output logic       oHalt
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_known;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) r_state <= c_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    case (iOp)
      c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ, c_OP_ADDI, c_OP_J: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_FETCH: w_next = c_DECODE;
      c_DECODE: begin
        case (iOp)
          c_OP_LW, c_OP_SW: w_next = c_MEMADR;
          c_OP_RTYPE:       w_next = c_EXEC;
          c_OP_BEQ:         w_next = c_BRANCH;
          c_OP_ADDI:        w_next = c_ADDIEX;
          c_OP_J:           w_next = c_JUMP;
          default:          w_next = TRAP_ILLEGAL ? c_HALT : c_FETCH;
        endcase
      end
      c_MEMADR: w_next = (iOp == c_OP_LW) ? c_MEMRD : c_MEMWR;
      c_MEMRD:  w_next = c_MEMWB;
      c_EXEC:   w_next = c_ALUWB;
      c_ADDIEX: w_next = c_ADDIWB;
      c_HALT:   w_next = c_HALT;
      default:  w_next = c_FETCH;
    endcase
  end

  // ALUSrcB: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2.  PCSrc: 00 ALU, 01 ALUOut, 10 jump.
  always_comb begin
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oRegWrite    = 1'b0;
    oRegDst      = 1'b0;
    oMemtoReg    = 1'b0;
    oMemWrite    = 1'b0;
    oALUSrcA     = 1'b0;
    oALUSrcB     = 2'b00;
    oPCSrc       = 2'b00;
    oALUControl  = c_ALU_ADD;
    oAbWrite     = 1'b0;
    oMdrWrite    = 1'b0;
    oAluOutWrite = 1'b0;
    oRetire      = 1'b0;
    case (r_state)
      c_FETCH:  begin oIRWrite = 1'b1; oPCWrite = 1'b1; oALUSrcB = 2'b01; end
      c_DECODE: begin
        oALUSrcB = 2'b11; oAbWrite = 1'b1; oAluOutWrite = 1'b1;
        oRetire  = ~w_known & ~TRAP_ILLEGAL;
      end
      c_MEMADR: begin oALUSrcA = 1'b1; oALUSrcB = 2'b10; oAluOutWrite = 1'b1; end
      c_MEMRD:  oMdrWrite = 1'b1;
      c_MEMWB:  begin oRegWrite = 1'b1; oMemtoReg = 1'b1; oRetire = 1'b1; end
      c_MEMWR:  begin oMemWrite = 1'b1; oRetire = 1'b1; end
      c_EXEC:   begin oALUSrcA = 1'b1; oALUControl = functToAlu(iFunct); oAluOutWrite = 1'b1; end
      c_ALUWB:  begin oRegWrite = 1'b1; oRegDst = 1'b1; oRetire = 1'b1; end
      c_BRANCH: begin
        oALUSrcA = 1'b1; oALUControl = c_ALU_SUB; oPCWriteCond = 1'b1;
        oPCSrc   = 2'b01; oRetire = 1'b1;
      end
      c_ADDIEX: begin oALUSrcA = 1'b1; oALUSrcB = 2'b10; oAluOutWrite = 1'b1; end
      c_ADDIWB: begin oRegWrite = 1'b1; oRetire = 1'b1; end
      c_JUMP:   begin oPCWrite = 1'b1; oPCSrc = 2'b10; oRetire = 1'b1; end
      default:  ;
    endcase
  end

  assign oState = r_state;
  assign oHalt  = (r_state == c_HALT);

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile : 32x32 register file, two read ports, $0 reads as zero
// Rev 1.0
// ------------------------------------------------------------------
module regfile (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iWe,
  input  logic [4:0]  iRa1,
  input  logic [4:0]  iRa2,
  input  logic [4:0]  iWa,
  input  logic [31:0] iWd,
  output logic [31:0] oRd1,
  output logic [31:0] oRd2
);

  logic [31:0] r_regs [32];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (iWe && (iWa != 5'd0)) begin
      r_regs[iWa] <= iWd;
    end
  end

  assign oRd1 = (iRa1 == 5'd0) ? 32'd0 : r_regs[iRa1];
  assign oRd2 = (iRa2 == 5'd0) ? 32'd0 : r_regs[iRa2];

endmodule
`default_nettype wire

// File: rtl/mips_multicycle.sv
`default_nettype none
// ------------------------------------------------------------------
// mips_multicycle : multicycle MIPS datapath (lw/sw/R/beq/addi/j)
// Rev 1.0
// ------------------------------------------------------------------
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0]       RESET_PC     = 32'h0000_0000,
  parameter logic              TRAP_ILLEGAL = 1'b0,
  parameter logic [63:0][31:0] IMEM_INIT    = '0
) (
  input  logic        iClk,
  input  logic        iReset,
  output logic [31:0] oPC,
  output logic [3:0]  oState,
  output logic        oRetire,
  output logic        oHalt
);

  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluOut;
  logic [31:0] w_instr, w_rd1, w_rd2, w_memRd, w_signImm;
  logic [31:0] w_srcA, w_srcB, w_aluResult, w_pcNext, w_wd;
  logic [4:0]  w_wa;
  logic        w_zero, w_pcEn;
  logic        w_irWrite, w_pcWrite, w_pcWriteCond, w_regWrite, w_regDst;
  logic        w_memtoReg, w_memWrite, w_aluSrcA, w_abWrite, w_mdrWrite, w_aluOutWrite;
  logic [1:0]  w_aluSrcB, w_pcSrc;
  logic [2:0]  w_aluControl;

  mc_controller #(.TRAP_ILLEGAL(TRAP_ILLEGAL)) uCtrl (
    .iClk(iClk), .iReset(iReset), .iOp(r_ir[31:26]), .iFunct(r_ir[5:0]),
    .oState(oState), .oIRWrite(w_irWrite), .oPCWrite(w_pcWrite),
    .oPCWriteCond(w_pcWriteCond), .oRegWrite(w_regWrite), .oRegDst(w_regDst),
    .oMemtoReg(w_memtoReg), .oMemWrite(w_memWrite), .oALUSrcA(w_aluSrcA),
    .oALUSrcB(w_aluSrcB), .oPCSrc(w_pcSrc), .oALUControl(w_aluControl),
    .oAbWrite(w_abWrite), .oMdrWrite(w_mdrWrite), .oAluOutWrite(w_aluOutWrite),
    .oRetire(oRetire), .oHalt(oHalt)
  );

  imem #(.INIT(IMEM_INIT)) uImem (.iAddr(r_pc[7:2]), .oRd(w_instr));

  dmem uDmem (
    .iClk(iClk), .iWe(w_memWrite), .iAddr(r_aluOut[7:2]), .iWd(r_b), .oRd(w_memRd)
  );

  regfile uRegfile (
    .iClk(iClk), .iReset(iReset), .iWe(w_regWrite), .iRa1(r_ir[25:21]),
    .iRa2(r_ir[20:16]), .iWa(w_wa), .iWd(w_wd), .oRd1(w_rd1), .oRd2(w_rd2)
  );

  alu uAlu (.iA(w_srcA), .iB(w_srcB), .iCtrl(w_aluControl), .oY(w_aluResult), .oZero(w_zero));

  assign w_signImm = signExt(r_ir[15:0]);
  assign w_srcA    = w_aluSrcA ? r_a : r_pc;
  assign w_wa      = w_regDst ? r_ir[15:11] : r_ir[20:16];
  assign w_wd      = w_memtoReg ? r_mdr : r_aluOut;
  assign w_pcEn    = w_pcWrite | (w_pcWriteCond & w_zero);

  always_comb begin
    case (w_aluSrcB)
      2'b00:   w_srcB = r_b;
      2'b01:   w_srcB = 32'd4;
      2'b10:   w_srcB = w_signImm;
      default: w_srcB = {w_signImm[29:0], 2'b00};
    endcase
  end

  // PC already holds PC+4 by the time a jump executes.
  always_comb begin
    case (w_pcSrc)
      2'b00:   w_pcNext = w_aluResult;
      2'b01:   w_pcNext = r_aluOut;
      default: w_pcNext = {r_pc[31:28], r_ir[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluOut <= '0;
    end else begin
      if (w_irWrite)     r_ir     <= w_instr;
      if (w_pcEn)        r_pc     <= w_pcNext;
      if (w_mdrWrite)    r_mdr    <= w_memRd;
      if (w_aluOutWrite) r_aluOut <= w_aluResult;
      if (w_abWrite) begin
        r_a <= w_rd1;
        r_b <= w_rd2;
      end
    end
  end

  assign oPC = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mips_multicycle : directed self-checking bench, four core instances
// Rev 1.0
// ------------------------------------------------------------------
module tb_mips_multicycle;
  import mips_pkg::*;

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [63:0][31:0] prog0();
    logic [63:0][31:0] p;
    p = '0;
    p[16] = encI(6'h08, 5'd0, 5'd1, 16'd5);        // 0x40 addi $1,$0,5
    p[17] = encI(6'h08, 5'd0, 5'd2, 16'd7);        // 0x44 addi $2,$0,7
    p[18] = encR(5'd1, 5'd2, 5'd3, 6'h20);         // 0x48 add  $3,$1,$2
    p[19] = encI(6'h2B, 5'd0, 5'd3, 16'd8);        // 0x4C sw   $3,8($0)
    p[20] = encI(6'h23, 5'd0, 5'd4, 16'd8);        // 0x50 lw   $4,8($0)
    p[21] = encR(5'd1, 5'd2, 5'd5, 6'h22);         // 0x54 sub
    p[22] = encR(5'd1, 5'd2, 5'd6, 6'h24);         // 0x58 and
    p[23] = encR(5'd1, 5'd2, 5'd7, 6'h25);         // 0x5C or
    p[24] = encR(5'd1, 5'd2, 5'd8, 6'h2A);         // 0x60 slt
    p[25] = encI(6'h08, 5'd0, 5'd0, 16'd9);        // 0x64 addi $0,$0,9
    p[26] = encI(6'h04, 5'd1, 5'd2, 16'd5);        // 0x68 beq $1,$2 (not taken)
    p[27] = {6'h3F, 26'd0};                        // 0x6C illegal
    p[28] = encI(6'h04, 5'd0, 5'd0, 16'hFFFF);     // 0x70 beq $0,$0,-1
    return p;
  endfunction

  function automatic logic [63:0][31:0] prog1();
    logic [63:0][31:0] p;
    p = '0;
    p[4] = encI(6'h04, 5'd1, 5'd1, 16'hFFFF);      // 0x10 beq $1,$1,-1
    return p;
  endfunction

  function automatic logic [63:0][31:0] prog2();
    logic [63:0][31:0] p;
    p = '0;
    p[8] = {6'h02, 26'h100};                       // 0x20 j 0x400
    return p;
  endfunction

  function automatic logic [63:0][31:0] prog3();
    logic [63:0][31:0] p;
    p = '0;
    p[0] = encI(6'h08, 5'd0, 5'd5, 16'h55);
    p[1] = encI(6'h2B, 5'd0, 5'd5, 16'd16);
    p[2] = encI(6'h08, 5'd0, 5'd6, 16'h66);
    p[3] = encI(6'h2B, 5'd0, 5'd6, 16'd16);
    p[4] = {6'h3F, 26'd0};
    return p;
  endfunction

  localparam logic [63:0][31:0] P0 = prog0();
  localparam logic [63:0][31:0] P1 = prog1();
  localparam logic [63:0][31:0] P2 = prog2();
  localparam logic [63:0][31:0] P3 = prog3();

  logic        iClk = 1'b0;
  logic        rst0, rst1, rst2, rst3;
  logic [31:0] pc0, pc1, pc2, pc3;
  logic [3:0]  st0, st1, st2, st3;
  logic        ret0, ret1, ret2, ret3;
  logic        halt0, halt1, halt2, halt3;
  int          checks = 0;
  int          failures = 0;

  always #5 iClk = ~iClk;

  mips_multicycle #(.RESET_PC(32'h40), .TRAP_ILLEGAL(1'b0), .IMEM_INIT(P0)) u0 (
    .iClk(iClk), .iReset(rst0), .oPC(pc0), .oState(st0), .oRetire(ret0), .oHalt(halt0));
  mips_multicycle #(.RESET_PC(32'h10), .TRAP_ILLEGAL(1'b0), .IMEM_INIT(P1)) u1 (
    .iClk(iClk), .iReset(rst1), .oPC(pc1), .oState(st1), .oRetire(ret1), .oHalt(halt1));
  mips_multicycle #(.RESET_PC(32'h20), .TRAP_ILLEGAL(1'b0), .IMEM_INIT(P2)) u2 (
    .iClk(iClk), .iReset(rst2), .oPC(pc2), .oState(st2), .oRetire(ret2), .oHalt(halt2));
  mips_multicycle #(.RESET_PC(32'h00), .TRAP_ILLEGAL(1'b1), .IMEM_INIT(P3)) u3 (
    .iClk(iClk), .iReset(rst3), .oPC(pc3), .oState(st3), .oRetire(ret3), .oHalt(halt3));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int expRet0 [16] = '{4, 8, 12, 16, 21, 25, 29, 33, 37, 41, 44, 46, 49, 52, 55, 58};
  int expRet1 [3]  = '{3, 6, 9};
  int gotRet [16];
  int nRet;
  int lateRet;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    // ---- u0: reset values, then the main program ----
    @(negedge iClk);
    checkEq("rst_pc", pc0, 32'h40);
    checkEq("rst_state", 32'(st0), 32'd0);
    checkEq("rst_halt", 32'(halt0), 32'd0);
    checkEq("rst_retire", 32'(ret0), 32'd0);
    rst0 = 1'b0;
    nRet = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (ret0) begin
        if (nRet < 16) gotRet[nRet] = cyc;
        nRet++;
      end
      if (cyc == 2)  checkEq("decode_state", 32'(st0), 32'd1);
      if (cyc == 3)  checkEq("pc_after_2_edges", pc0, 32'h44);
      if (cyc == 45) checkEq("beq_not_taken_pc", pc0, 32'h6C);
      if (cyc == 47) checkEq("illegal_nop_pc", pc0, 32'h70);
      if (cyc == 50) checkEq("beq_loop_pc", pc0, 32'h70);
      @(posedge iClk); #1;
    end
    checkEq("retire_count0", 32'(nRet), 32'd16);
    for (int i = 0; i < 16; i++) checkEq("retire_cycle0", 32'(gotRet[i]), 32'(expRet0[i]));
    checkEq("reg1", u0.uRegfile.r_regs[1], 32'd5);
    checkEq("reg2", u0.uRegfile.r_regs[2], 32'd7);
    checkEq("add_reg3", u0.uRegfile.r_regs[3], 32'd12);
    checkEq("sw_dmem8", u0.uDmem.r_mem[2], 32'd12);
    checkEq("lw_reg4", u0.uRegfile.r_regs[4], 32'd12);
    checkEq("sub_reg5", u0.uRegfile.r_regs[5], 32'hFFFF_FFFE);
    checkEq("and_reg6", u0.uRegfile.r_regs[6], 32'd5);
    checkEq("or_reg7", u0.uRegfile.r_regs[7], 32'd7);
    checkEq("slt_reg8", u0.uRegfile.r_regs[8], 32'd1);
    checkEq("reg0_zero", u0.uRegfile.r_regs[0], 32'd0);

    // ---- u1: beq to itself every 3 cycles ----
    @(negedge iClk);
    rst1 = 1'b0;
    nRet = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (ret1) begin
        if (nRet < 16) gotRet[nRet] = cyc;
        nRet++;
      end
      if (cyc == 3) checkEq("branch_state", 32'(st1), 32'd8);
      if (cyc == 4 || cyc == 7 || cyc == 10) checkEq("beq_self_pc", pc1, 32'h10);
      @(posedge iClk); #1;
    end
    checkEq("retire_count1", 32'(nRet), 32'd3);
    for (int i = 0; i < 3; i++) checkEq("retire_cycle1", 32'(gotRet[i]), 32'(expRet1[i]));

    // ---- u2: jump ----
    @(negedge iClk);
    rst2 = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc == 3) begin
        checkEq("jump_state", 32'(st2), 32'd11);
        checkEq("jump_retire", 32'(ret2), 32'd1);
        checkEq("jump_pc_before", pc2, 32'h24);
      end
      if (cyc == 4) checkEq("jump_target", pc2, 32'h400);
      @(posedge iClk); #1;
    end

    // ---- u3: illegal opcode traps to HALT ----
    @(negedge iClk);
    rst3 = 1'b0;
    lateRet = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc >= 17 && ret3) lateRet++;
      if (cyc == 18) checkEq("halt_not_yet", 32'(halt3), 32'd0);
      if (cyc == 19) checkEq("halt_enter", 32'(halt3), 32'd1);
      @(posedge iClk); #1;
    end
    checkEq("halt_stays", 32'(halt3), 32'd1);
    checkEq("halt_state", 32'(st3), 32'd12);
    checkEq("halt_pc", pc3, 32'h14);
    checkEq("halt_no_retire", 32'(lateRet), 32'd0);
    checkEq("sw2_dmem16", u3.uDmem.r_mem[4], 32'h66);

    // ---- u3: reset during MEMWR of the first sw ----
    @(negedge iClk);
    rst3 = 1'b1;
    @(negedge iClk);
    rst3 = 1'b0;
    repeat (7) @(posedge iClk);
    #1;
    checkEq("memwr_state", 32'(st3), 32'd5);
    #2;
    rst3 = 1'b1;
    #1;
    checkEq("abort_state", 32'(st3), 32'd0);
    checkEq("abort_pc", pc3, 32'h0);
    @(posedge iClk); #1;
    @(negedge iClk);
    rst3 = 1'b0;
    #1;
    checkEq("abort_dmem_kept", u3.uDmem.r_mem[4], 32'h66);
    checkEq("abort_reg_clear", u3.uRegfile.r_regs[5], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
